rob_commit_ctrl: RTL
====================

Name: rob_commit_ctrl

Overview:
Reorder-buffer controller for the out-of-order RISC-V core. It allocates 5-bit rename tags (Q) to the dispatcher and captures results from the CDB. It retires entries in program order, driving the RegFile commit port (commit flag, rd, Q, V). It is the single sequencer of RegFile writes and of global rollback on branch mispredict.

Parameters:
ROB_SIZE, 16, number of entries; power of two, at most 16 (tag = index+1, tag 0 = "ready/no producer").
IDX_W, 4, log2(ROB_SIZE) index width.

Ports:
clk_in  input  1  core clock
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  global enable; low freezes all state
alloc_flag_from_dispatcher  input  1  allocate one entry this cycle
rd_from_dispatcher  input  5  destination register of allocated instr
is_branch_from_dispatcher  input  1  allocated instr is a branch/jalr
pred_jump_from_dispatcher  input  1  predicted taken
full_to_dispatcher  output  1  no free entry (combinational)
Q_to_dispatcher  output  5  tag the next allocation receives (combinational, head-independent)
query_Q1_from_dispatcher, query_Q2_from_dispatcher  input  5 each  tags to look up
ready1_to_dispatcher, ready2_to_dispatcher  output  1 each  looked-up entry has result
V1_to_dispatcher, V2_to_dispatcher  output  32 each  looked-up result value
cdb_flag  input  1  result broadcast valid
cdb_Q  input  5  producing tag
cdb_V  input  32  result value
cdb_jump  input  1  actual branch outcome (branches only)
cdb_pc  input  32  correct next PC (branches only)
commit_flag_to_regfile  output  1  one-cycle retire pulse
rd_to_regfile  output  5  retired rd
Q_to_regfile  output  5  retired tag
V_to_regfile  output  32  retired value
rollback_flag_to_all  output  1  one-cycle flush pulse
pc_to_fetcher  output  32  redirect PC, valid with rollback flag

Behaviour:
- Reset (async, rst_in=1): head=tail=count=0, all entries busy=0/ready=0; all registered outputs 0. Reset mid-operation discards all in-flight entries.
- rdy_in=0: no state change; commit and rollback flags driven 0 on the next edge.
- full_to_dispatcher = (count==ROB_SIZE). Q_to_dispatcher = tail+1.
- Allocation: on edge with alloc_flag && !full && !rollback, write entry[tail] {busy=1, ready=0, rd, is_branch, pred}, tail=tail+1 mod ROB_SIZE. Alloc while full is ignored.
- CDB: on edge with cdb_flag and cdb_Q!=0, entry[cdb_Q-1] gets V=cdb_V, jump=cdb_jump, pc=cdb_pc, ready=1. A CDB hit on a non-busy entry is ignored.
- Query: for Qn!=0, readyN = entry ready OR (cdb_flag && cdb_Q==Qn), with V bypassed from cdb_V on a CDB hit. Qn=0 gives ready=0 and V=0.
- Commit: when count>0 and entry[head] is registered-ready (no CDB bypass), on the edge commit_flag=1, rd/Q/V = entry fields, Q=head+1, busy=0, head=head+1. Latency is one cycle from CDB write to commit pulse. At most one commit per cycle. rd=0 entries still pulse with rd=0.
- Mispredict: when the committing entry is a branch and jump!=pred, in the same edge also set rollback_flag=1 and pc_to_fetcher=entry pc. Clear all busy/ready, head=tail=count=0. A same-cycle allocation is dropped.
- count: +1 on alloc only, -1 on commit only, unchanged on both, 0 on rollback.
- Wrap-around: head and tail wrap mod ROB_SIZE. Full and empty are distinguished by count, not pointer equality.
- Flags are single-cycle pulses; when a flag is 0, the data outputs hold their last value.

Decomposition:
- Shared package riscv_defs: TAG_W=5, XLEN=32, NULL_TAG=0, ROB_SIZE default, rob_entry_t {busy, ready, rd, is_branch, pred, jump, V, pc}.
- One sub-module, rob_entry_array: entry storage with alloc and CDB write ports, head read port, and two query read ports with CDB bypass. rob_commit_ctrl keeps head/tail/count, commit and rollback sequencing.

Test Plan:
- Reset then alloc rd=5 → Q_to_dispatcher=1. CDB Q=1 V=0x1234 → next edge commit_flag=1, rd=5, Q=1, V=0x1234; count returns 0.
- Allocate 16 entries with no CDB → full=1 after 16th. 17th alloc ignored, and Q_to_dispatcher stays 1 (tail wrapped to 0).
- Out-of-order CDB: alloc tags 1,2,3; CDB 3 then 2 then 1 → commits of 1,2,3 on consecutive cycles in order.
- Branch tag 2 pred=0, CDB jump=1 pc=0x80 → on its commit edge rollback=1, pc=0x80. Tag 3 never commits; next alloc gets Q=1.
- Query Q1=4 while CDB broadcasts Q=4 V=7 the same cycle → ready1=1, V1=7 combinationally.
- Assert rst_in mid-stream with 5 entries busy → outputs 0 immediately, count=0, no commit after release.

Source files
------------

// File: rtl/riscv_defs.sv
// Core-wide widths and the reorder-buffer entry record shared by the ROB files.
package riscv_defs;

  localparam int TAG_W            = 5;
  localparam int XLEN             = 32;
  localparam int REG_W            = 5;
  localparam int ROB_SIZE_DEFAULT = 16;

  // Tag 0 means "value ready / no producer"; live tags are index+1.
  localparam logic [TAG_W-1:0] NULL_TAG = '0;

  typedef struct packed {
    logic             busy;
    logic             ready;
    logic [REG_W-1:0] rd;
    logic             is_branch;
    logic             pred;
    logic             jump;
    logic [XLEN-1:0]  v;
    logic [XLEN-1:0]  pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Dispatcher, CDB and RegFile/fetch-redirect signal bundle of the reorder buffer.
interface rob_commit_ctrl_if;
  import riscv_defs::*;

  // Handshake: alloc_flag is a one-cycle request honoured only while full is low;
  // cdb_flag qualifies cdb_* for one cycle; commit/rollback flags are one-cycle
  // pulses qualifying their data, which otherwise holds its last value.
  logic             alloc_flag_from_dispatcher;
  logic [REG_W-1:0] rd_from_dispatcher;
  logic             is_branch_from_dispatcher;
  logic             pred_jump_from_dispatcher;
  logic             full_to_dispatcher;
  logic [TAG_W-1:0] Q_to_dispatcher;
  logic [TAG_W-1:0] query_Q1_from_dispatcher;
  logic [TAG_W-1:0] query_Q2_from_dispatcher;
  logic             ready1_to_dispatcher;
  logic             ready2_to_dispatcher;
  logic [XLEN-1:0]  V1_to_dispatcher;
  logic [XLEN-1:0]  V2_to_dispatcher;
  logic             cdb_flag;
  logic [TAG_W-1:0] cdb_Q;
  logic [XLEN-1:0]  cdb_V;
  logic             cdb_jump;
  logic [XLEN-1:0]  cdb_pc;
  logic             commit_flag_to_regfile;
  logic [REG_W-1:0] rd_to_regfile;
  logic [TAG_W-1:0] Q_to_regfile;
  logic [XLEN-1:0]  V_to_regfile;
  logic             rollback_flag_to_all;
  logic [XLEN-1:0]  pc_to_fetcher;

  modport slave (
    input  alloc_flag_from_dispatcher, rd_from_dispatcher, is_branch_from_dispatcher,
           pred_jump_from_dispatcher, query_Q1_from_dispatcher, query_Q2_from_dispatcher,
           cdb_flag, cdb_Q, cdb_V, cdb_jump, cdb_pc,
    output full_to_dispatcher, Q_to_dispatcher, ready1_to_dispatcher, ready2_to_dispatcher,
           V1_to_dispatcher, V2_to_dispatcher, commit_flag_to_regfile, rd_to_regfile,
           Q_to_regfile, V_to_regfile, rollback_flag_to_all, pc_to_fetcher
  );

  modport master (
    output alloc_flag_from_dispatcher, rd_from_dispatcher, is_branch_from_dispatcher,
           pred_jump_from_dispatcher, query_Q1_from_dispatcher, query_Q2_from_dispatcher,
           cdb_flag, cdb_Q, cdb_V, cdb_jump, cdb_pc,
    input  full_to_dispatcher, Q_to_dispatcher, ready1_to_dispatcher, ready2_to_dispatcher,
           V1_to_dispatcher, V2_to_dispatcher, commit_flag_to_regfile, rd_to_regfile,
           Q_to_regfile, V_to_regfile, rollback_flag_to_all, pc_to_fetcher
  );

endinterface

// File: rtl/rob_entry_array.sv
// ROB entry storage: allocate and CDB write ports, retire/flush clears, head read
// port and two operand-query read ports with same-cycle CDB bypass.
module rob_entry_array
  import riscv_defs::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEFAULT,
  parameter int IDX_W    = $clog2(ROB_SIZE)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en,
  input  logic             flush,
  input  logic             alloc_we,
  input  logic [IDX_W-1:0] alloc_idx,
  input  logic [REG_W-1:0] alloc_rd,
  input  logic             alloc_is_branch,
  input  logic             alloc_pred,
  input  logic             cdb_flag,
  input  logic [TAG_W-1:0] cdb_q,
  input  logic [XLEN-1:0]  cdb_v,
  input  logic             cdb_jump,
  input  logic [XLEN-1:0]  cdb_pc,
  input  logic             retire_we,
  input  logic [IDX_W-1:0] head_idx,
  output rob_entry_t       head_entry,
  input  logic [TAG_W-1:0] query_q1,
  input  logic [TAG_W-1:0] query_q2,
  output logic             ready1,
  output logic [XLEN-1:0]  v1,
  output logic             ready2,
  output logic [XLEN-1:0]  v2
);

  rob_entry_t entries [ROB_SIZE];

  function automatic logic [IDX_W-1:0] tag_to_idx(input logic [TAG_W-1:0] tag);
    logic [TAG_W-1:0] t;
    t = tag - TAG_W'(1);
    return t[IDX_W-1:0];
  endfunction

  function automatic logic tag_live(input logic [TAG_W-1:0] tag);
    return (tag != NULL_TAG) && (tag <= TAG_W'(ROB_SIZE));
  endfunction

  logic [IDX_W-1:0] cdb_idx, q1_idx, q2_idx;
  logic             cdb_hit;

  assign cdb_idx    = tag_to_idx(cdb_q);
  assign q1_idx     = tag_to_idx(query_q1);
  assign q2_idx     = tag_to_idx(query_q2);
  assign cdb_hit    = cdb_flag && tag_live(cdb_q) && entries[cdb_idx].busy;
  assign head_entry = entries[head_idx];

  // Retire clears only busy: ready/V stay visible so a dispatcher still holding
  // the tag from the RegFile (written one edge later) reads the result.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < ROB_SIZE; i++) entries[i] <= '0;
    end else if (en) begin
      if (flush) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          entries[i].busy  <= 1'b0;
          entries[i].ready <= 1'b0;
        end
      end else begin
        if (cdb_hit) begin
          entries[cdb_idx].ready <= 1'b1;
          entries[cdb_idx].v     <= cdb_v;
          entries[cdb_idx].jump  <= cdb_jump;
          entries[cdb_idx].pc    <= cdb_pc;
        end
        if (retire_we) entries[head_idx].busy <= 1'b0;
        if (alloc_we) begin
          entries[alloc_idx].busy      <= 1'b1;
          entries[alloc_idx].ready     <= 1'b0;
          entries[alloc_idx].rd        <= alloc_rd;
          entries[alloc_idx].is_branch <= alloc_is_branch;
          entries[alloc_idx].pred      <= alloc_pred;
        end
      end
    end
  end

  always_comb begin
    ready1 = 1'b0;
    v1     = '0;
    if (tag_live(query_q1)) begin
      if (cdb_flag && (cdb_q == query_q1)) begin
        ready1 = 1'b1;
        v1     = cdb_v;
      end else begin
        ready1 = entries[q1_idx].ready;
        v1     = entries[q1_idx].v;
      end
    end
  end

  always_comb begin
    ready2 = 1'b0;
    v2     = '0;
    if (tag_live(query_q2)) begin
      if (cdb_flag && (cdb_q == query_q2)) begin
        ready2 = 1'b1;
        v2     = cdb_v;
      end else begin
        ready2 = entries[q2_idx].ready;
        v2     = entries[q2_idx].v;
      end
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer controller: tag allocation, in-order retire to the RegFile and
// global rollback on a mispredicted branch at the head.
module rob_commit_ctrl
  import riscv_defs::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEFAULT,
  parameter int IDX_W    = $clog2(ROB_SIZE)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  rob_commit_ctrl_if.slave bus
);

  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count;
  rob_entry_t       head_entry;
  logic             full, commit_go, mispredict, alloc_go;

  logic             commit_flag_q, rollback_flag_q;
  logic [REG_W-1:0] rd_q;
  logic [TAG_W-1:0] q_q;
  logic [XLEN-1:0]  v_q, pc_q;

  assign full = (count == (IDX_W+1)'(ROB_SIZE));

  // Commit uses only the registered ready bit, never the CDB bypass.
  assign commit_go  = (count != '0) && head_entry.busy && head_entry.ready;
  assign mispredict = commit_go && head_entry.is_branch && (head_entry.jump != head_entry.pred);
  assign alloc_go   = bus.alloc_flag_from_dispatcher && !full && !mispredict;

  rob_entry_array #(.ROB_SIZE(ROB_SIZE), .IDX_W(IDX_W)) u_entries (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .en              (rdy_in),
    .flush           (mispredict),
    .alloc_we        (alloc_go),
    .alloc_idx       (tail),
    .alloc_rd        (bus.rd_from_dispatcher),
    .alloc_is_branch (bus.is_branch_from_dispatcher),
    .alloc_pred      (bus.pred_jump_from_dispatcher),
    .cdb_flag        (bus.cdb_flag),
    .cdb_q           (bus.cdb_Q),
    .cdb_v           (bus.cdb_V),
    .cdb_jump        (bus.cdb_jump),
    .cdb_pc          (bus.cdb_pc),
    .retire_we       (commit_go),
    .head_idx        (head),
    .head_entry      (head_entry),
    .query_q1        (bus.query_Q1_from_dispatcher),
    .query_q2        (bus.query_Q2_from_dispatcher),
    .ready1          (bus.ready1_to_dispatcher),
    .v1              (bus.V1_to_dispatcher),
    .ready2          (bus.ready2_to_dispatcher),
    .v2              (bus.V2_to_dispatcher)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      commit_flag_q   <= 1'b0;
      rollback_flag_q <= 1'b0;
      rd_q            <= '0;
      q_q             <= '0;
      v_q             <= '0;
      pc_q            <= '0;
    end else if (!rdy_in) begin
      commit_flag_q   <= 1'b0;
      rollback_flag_q <= 1'b0;
    end else begin
      commit_flag_q   <= commit_go;
      rollback_flag_q <= mispredict;
      if (commit_go) begin
        rd_q <= head_entry.rd;
        q_q  <= TAG_W'(head) + TAG_W'(1);
        v_q  <= head_entry.v;
      end
      if (mispredict) begin
        pc_q  <= head_entry.pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (commit_go) head <= head + IDX_W'(1);
        if (alloc_go)  tail <= tail + IDX_W'(1);
        unique case ({alloc_go, commit_go})
          2'b10:   count <= count + (IDX_W+1)'(1);
          2'b01:   count <= count - (IDX_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign bus.full_to_dispatcher     = full;
  assign bus.Q_to_dispatcher        = TAG_W'(tail) + TAG_W'(1);
  assign bus.commit_flag_to_regfile = commit_flag_q;
  assign bus.rd_to_regfile          = rd_q;
  assign bus.Q_to_regfile           = q_q;
  assign bus.V_to_regfile           = v_q;
  assign bus.rollback_flag_to_all   = rollback_flag_q;
  assign bus.pc_to_fetcher          = pc_q;

endmodule
